// File: rtl/new_game_text_renderer.sv
// new_game_text_renderer: maps VGA pixels onto 8 glyph slots, reads the 20x20 letter ROM
// and emits a 3-clock-latency pixel_on with per-slot frame-counted blinking.
module new_game_text_renderer #(
    parameter int          TEXT_X0      = 220,
    parameter int          TEXT_Y0      = 230,
    parameter int          PITCH        = 24,
    parameter int          NUM_LETTERS  = 8,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [7:0]  BLINK_MASK   = 8'b11110000
) (
    input  logic         clock_25_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic [9:0]   pixel_x_i,
    input  logic [9:0]   pixel_y_i,
    input  logic         frame_tick_i,
    output logic [3:0]   selected_letter_o,
    input  logic [399:0] letter_count_i,
    output logic         pixel_on_o
);
    typedef enum logic {SHOW, HIDE} state_t;
    localparam logic [9:0] SPAN = 10'(NUM_LETTERS * PITCH);
    localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);
    logic [9:0] dx, dy, base;
    logic [2:0] slot;
    logic [4:0] col_d, row_d, row1_q, col1_q, row2_q, col2_q;
    logic       in_box, hit_d, hit1_q, hit2_q, blink1_q, blink2_q;
    logic [8:0] pos;
    logic       pixel_on_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    // Slot select by comparison chain so no divider is inferred.
    always_comb begin
        dx = pixel_x_i - 10'(TEXT_X0);
        dy = pixel_y_i - 10'(TEXT_Y0);
        slot = '0;
        base = '0;
        for (int k = 1; k < NUM_LETTERS; k++)
            if (dx >= 10'(k * PITCH)) begin
                slot = 3'(k);
                base = 10'(k * PITCH);
            end
        col_d = 5'(dx - base);
        row_d = dy[4:0];
        in_box = pixel_x_i >= 10'(TEXT_X0) && pixel_y_i >= 10'(TEXT_Y0) && dx < SPAN && dy < 10'd20;
        hit_d = enable_i && in_box && col_d < 5'd20;
    end
    // Row-major bitmap, MSB at top-left; only meaningful while hit2_q is set.
    always_comb begin
        pos = 9'd399 - (9'(row2_q) * 9'd20 + 9'(col2_q));
        pixel_on_d = hit2_q && letter_count_i[pos] && !(blink2_q && state_q == HIDE);
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        if (!enable_i) begin
            state_d = SHOW;
            cnt_d = '0;
        end else if (frame_tick_i) begin
            cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
            state_d = (cnt_q == LAST) ? ((state_q == SHOW) ? HIDE : SHOW) : state_q;
        end
    end
    always_ff @(posedge clock_25_i or posedge reset_i) begin
        if (reset_i) begin
            selected_letter_o <= '0;
            row1_q <= '0;
            col1_q <= '0;
            hit1_q <= 1'b0;
            blink1_q <= 1'b0;
            row2_q <= '0;
            col2_q <= '0;
            hit2_q <= 1'b0;
            blink2_q <= 1'b0;
            pixel_on_o <= 1'b0;
            state_q <= SHOW;
            cnt_q <= '0;
        end else begin
            if (in_box) selected_letter_o <= {1'b0, slot};
            row1_q <= row_d;
            col1_q <= col_d;
            hit1_q <= hit_d;
            blink1_q <= BLINK_MASK[slot];
            row2_q <= row1_q;
            col2_q <= col1_q;
            hit2_q <= hit1_q;
            blink2_q <= blink1_q;
            pixel_on_o <= pixel_on_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_new_game_text_renderer.sv
// tb_new_game_text_renderer: random and directed pixels against a slot/row/col
// reference model with a registered glyph ROM and blink-phase tracking.
module tb_new_game_text_renderer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic [9:0]   pixel_x = '0;
    logic [9:0]   pixel_y = '0;
    logic         frame_tick = 1'b0;
    logic [3:0]   selected_letter;
    logic [399:0] letter_count;
    logic         pixel_on;

    localparam logic [7:0] MASK = 8'b11110000;
    bit           g [8][20][20];
    logic [399:0] rom [8];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           q [$];
    int           exp_sel = 0;
    int           ticks = 0;
    bit           hide = 0;

    new_game_text_renderer dut (
        .clock_25_i(clk),
        .reset_i(reset),
        .enable_i(enable),
        .pixel_x_i(pixel_x),
        .pixel_y_i(pixel_y),
        .frame_tick_i(frame_tick),
        .selected_letter_o(selected_letter),
        .letter_count_i(letter_count),
        .pixel_on_o(pixel_on)
    );

    always #5 clk = ~clk;
    always @(posedge clk) letter_count <= rom[selected_letter[2:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_pix(input int x, input int y);
        int dx, dy, s, c;
        if (x < 220 || y < 230 || !enable) return 1'b0;
        dx = x - 220;
        dy = y - 230;
        if (dx >= 192 || dy >= 20) return 1'b0;
        s = dx / 24;
        c = dx % 24;
        if (c >= 20) return 1'b0;
        return g[s][dy][c] && !(MASK[s] && hide);
    endfunction

    task automatic step(input int x, input int y, input bit tk);
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        frame_tick = tk;
        q.push_back(ref_pix(x, y));
        if (x >= 220 && y >= 230 && x - 220 < 192 && y - 230 < 20) exp_sel = (x - 220) / 24;
        @(posedge clk);
        #1;
        if (!enable) begin
            ticks = 0;
            hide = 0;
        end else if (tk) begin
            ticks++;
            if (ticks == 30) begin
                ticks = 0;
                hide = !hide;
            end
        end
        frame_tick = 1'b0;
        chk("sel", selected_letter, exp_sel);
        if (q.size() == 3) chk("pix", pixel_on, q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0);
    endtask

    task automatic ticks_n(input int n);
        idle(2);
        for (int i = 0; i < n; i++) step(0, 0, 1'b1);
    endtask

    task automatic rand_stream(input int n);
        for (int i = 0; i < n; i++)
            if (i % 8 == 7) step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
            else step(200 + int'($urandom_range(0, 230)), 225 + int'($urandom_range(0, 29)), 1'b0);
    endtask

    initial begin
        logic [399:0] v;
        for (int s = 0; s < 8; s++)
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++) g[s][r][c] = bit'($urandom_range(0, 1));
        g[0][0][0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            g[1][0][c] = 1'b1;
            g[7][0][c] = 1'b1;
            g[4][0][c] = (c >= 6 && c <= 15);
        end
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) g[3][r][c] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            v = '0;
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++) v = {v[398:0], logic'(g[s][r][c])};
            rom[s] = v;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix", pixel_on, 0);
        chk("rst_sel", selected_letter, 0);
        @(negedge clk);
        reset = 1'b0;
        q = {1'b0, 1'b0};
        step(220, 230, 1'b0);
        step(244, 230, 1'b0);
        step(240, 230, 1'b0);
        step(219, 230, 1'b0);
        step(220, 250, 1'b0);
        idle(3);
        for (int x = 316; x <= 335; x++) step(x, 230, 1'b0);
        idle(3);
        rand_stream(300);
        ticks_n(30);
        step(322, 230, 1'b0);
        step(220, 230, 1'b0);
        rand_stream(100);
        ticks_n(30);
        step(322, 230, 1'b0);
        ticks_n(30);
        step(322, 230, 1'b0);
        idle(2);
        enable = 1'b0;
        step(322, 230, 1'b1);
        for (int i = 0; i < 40; i++) step(200 + int'($urandom_range(0, 230)), 230 + int'($urandom_range(0, 19)), 1'b1);
        enable = 1'b1;
        step(322, 230, 1'b0);
        ticks_n(29);
        step(322, 230, 1'b0);
        ticks_n(1);
        step(322, 230, 1'b0);
        step(244, 230, 1'b0);
        idle(2);
        reset = 1'b1;
        #2;
        chk("async_pix", pixel_on, 0);
        chk("async_sel", selected_letter, 0);
        @(negedge clk);
        pixel_x = '0;
        pixel_y = '0;
        reset = 1'b0;
        q = {1'b0, 1'b0};
        exp_sel = 0;
        ticks = 0;
        hide = 0;
        step(322, 230, 1'b0);
        rand_stream(200);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
